// File: rtl/matmul_pkg.sv
// Shared types for the matmul scheduler: engine dims/state encodings and the scheduler FSM states.
package matmul_pkg;

    localparam int DIMS_W = 64;

    typedef struct packed {
        logic [31:0] rows;
        logic [31:0] cols;
    } matmul_dims_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        COMPUTE = 3'd2,
        WRITE   = 3'd3,
        ERROR   = 3'd4
    } matmul_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_RECOVER
    } sched_state_t;

    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last', wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt
);

    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!w_found && req[(int'(last) + i) % N]) begin
                gnt[(int'(last) + i) % N] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_sched.sv
// Round-robin owner scheduler in front of a single matmul engine.
// Optional statistics outputs are built when MATMUL_SCHED_STATS_EN is defined.
module matmul_sched
    import matmul_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 16,
    parameter int STAT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DIMS_W-1:0]   dims_a_i,
    input  logic [N_REQ*DIMS_W-1:0]   dims_b_i,
    input  logic [N_REQ*32-1:0]       in_a_i,
    input  logic [N_REQ*32-1:0]       in_b_i,
    output logic [N_REQ-1:0]          gnt,
    output logic [IDX_W-1:0]          elem_idx,
    output logic                      out_valid,
    output logic [IDX_W-1:0]          out_idx,
    output logic [31:0]               out_c,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic                      busy,
    output logic                      mm_start,
    output logic [DIMS_W-1:0]         mm_dims_a,
    output logic [DIMS_W-1:0]         mm_dims_b,
    output logic [31:0]               mm_in_a,
    output logic [31:0]               mm_in_b,
    input  logic [2:0]                mm_state,
    input  logic [31:0]               mm_out_c
`ifdef MATMUL_SCHED_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]   jobs_ok,
    output logic [N_REQ*STAT_W-1:0]   jobs_err,
    output logic [STAT_W-1:0]         busy_cycles
`endif
);

    localparam int LW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || STAT_W < 1) begin : g_param_chk
        $error("matmul_sched: N_REQ must be 2..16 and STAT_W >= 1");
    end

    sched_state_t        r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [LW-1:0]       r_owner;
    logic [LW-1:0]       r_last;
    logic [N_REQ-1:0]    r_done;
    logic [N_REQ-1:0]    r_err;
    logic                r_start;
    logic [IDX_W-1:0]    r_elem;
    logic [IDX_W-1:0]    r_oidx;
    logic                r_seen_wr;

    logic [N_REQ-1:0]    w_arb_gnt;
    logic [LW-1:0]       w_arb_idx;
    matmul_state_t       w_mm_state;
    logic [DIMS_W-1:0]   w_dims_a [N_REQ];
    logic [DIMS_W-1:0]   w_dims_b [N_REQ];
    logic [31:0]         w_in_a   [N_REQ];
    logic [31:0]         w_in_b   [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_dims_a[g] = dims_a_i[g*DIMS_W +: DIMS_W];
        assign w_dims_b[g] = dims_b_i[g*DIMS_W +: DIMS_W];
        assign w_in_a[g]   = in_a_i[g*32 +: 32];
        assign w_in_b[g]   = in_b_i[g*32 +: 32];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req  (req),
        .last (r_last),
        .gnt  (w_arb_gnt)
    );

    assign w_arb_idx  = LW'(oh2idx(16'(w_arb_gnt)));
    assign w_mm_state = matmul_state_t'(mm_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RECOVER;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_last    <= LW'(N_REQ - 1);
            r_done    <= '0;
            r_err     <= '0;
            r_start   <= 1'b0;
            r_elem    <= '0;
            r_oidx    <= '0;
            r_seen_wr <= 1'b0;
        end else begin
            r_done  <= '0;
            r_err   <= '0;
            r_start <= 1'b0;
            case (r_state)
                // The engine has no reset, so wait for it to drain before granting again.
                S_RECOVER: begin
                    if (w_mm_state == IDLE) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (|req) begin
                        r_gnt     <= w_arb_gnt;
                        r_owner   <= w_arb_idx;
                        r_last    <= w_arb_idx;
                        r_start   <= 1'b1;
                        r_elem    <= '0;
                        r_oidx    <= '0;
                        r_seen_wr <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    case (w_mm_state)
                        READ:  r_elem <= r_elem + 1'b1;
                        WRITE: begin
                            r_oidx    <= r_oidx + 1'b1;
                            r_seen_wr <= 1'b1;
                        end
                        ERROR: begin
                            r_err   <= r_gnt;
                            r_gnt   <= '0;
                            r_state <= S_RECOVER;
                        end
                        IDLE: begin
                            if (r_seen_wr) begin
                                r_done    <= r_gnt;
                                r_gnt     <= '0;
                                r_elem    <= '0;
                                r_oidx    <= '0;
                                r_seen_wr <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
                default: r_state <= S_RECOVER;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign mm_start  = r_start;
    assign elem_idx  = r_elem;
    assign out_idx   = r_oidx;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_RUN) && (w_mm_state == WRITE);
    assign out_c     = mm_out_c;
    assign mm_dims_a = w_dims_a[r_owner];
    assign mm_dims_b = w_dims_b[r_owner];
    assign mm_in_a   = (|r_gnt) ? w_in_a[r_owner] : 32'd0;
    assign mm_in_b   = (|r_gnt) ? w_in_b[r_owner] : 32'd0;

`ifdef MATMUL_SCHED_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [STAT_W-1:0] r_jobs_ok  [N_REQ];
    logic [STAT_W-1:0] r_jobs_err [N_REQ];
    logic [STAT_W-1:0] r_busy_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_jobs_ok[i]  <= '0;
                r_jobs_err[i] <= '0;
            end
            r_busy_cyc <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_done[i]) r_jobs_ok[i]  <= sat_inc(r_jobs_ok[i]);
                if (r_err[i])  r_jobs_err[i] <= sat_inc(r_jobs_err[i]);
            end
            if (busy) r_busy_cyc <= sat_inc(r_busy_cyc);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        assign jobs_ok[g*STAT_W +: STAT_W]  = r_jobs_ok[g];
        assign jobs_err[g*STAT_W +: STAT_W] = r_jobs_err[g];
    end
    assign busy_cycles = r_busy_cyc;
`endif

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched with a behavioural matmul engine and requester models.
module tb_matmul_sched;
    import matmul_pkg::*;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [255:0]  dims_a_i, dims_b_i;
    logic [127:0]  in_a_i, in_b_i;
    logic [3:0]    gnt, done, err;
    logic [15:0]   elem_idx, out_idx;
    logic          out_valid, busy, mm_start;
    logic [31:0]   out_c, mm_in_a, mm_in_b, mm_out_c;
    logic [63:0]   mm_dims_a, mm_dims_b;
    logic [2:0]    mm_state;
`ifdef MATMUL_SCHED_STATS_EN
    logic [63:0]   jobs_ok, jobs_err;
    logic [15:0]   busy_cycles;
`endif

    matmul_sched #(.N_REQ(4), .IDX_W(16), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .dims_a_i(dims_a_i), .dims_b_i(dims_b_i), .in_a_i(in_a_i), .in_b_i(in_b_i),
        .gnt(gnt), .elem_idx(elem_idx), .out_valid(out_valid), .out_idx(out_idx),
        .out_c(out_c), .done(done), .err(err), .busy(busy), .mm_start(mm_start),
        .mm_dims_a(mm_dims_a), .mm_dims_b(mm_dims_b), .mm_in_a(mm_in_a), .mm_in_b(mm_in_b),
        .mm_state(mm_state), .mm_out_c(mm_out_c)
`ifdef MATMUL_SCHED_STATS_EN
        , .jobs_ok(jobs_ok), .jobs_err(jobs_err), .busy_cycles(busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester side: per-requester dims and row-major matrices, streamed by elem_idx.
    int unsigned ra[4], ka[4], kb[4], cb[4];
    logic [31:0] ma[4][16], mb[4][16];

    always_comb begin
        dims_a_i = '0;
        dims_b_i = '0;
        in_a_i   = '0;
        in_b_i   = '0;
        for (int q = 0; q < 4; q++) begin
            dims_a_i[q*64 +: 64] = {32'(ra[q]), 32'(ka[q])};
            dims_b_i[q*64 +: 64] = {32'(kb[q]), 32'(cb[q])};
            if (int'(elem_idx) < int'(ra[q]*ka[q])) in_a_i[q*32 +: 32] = ma[q][elem_idx[3:0]];
            if (int'(elem_idx) < int'(kb[q]*cb[q])) in_b_i[q*32 +: 32] = mb[q][elem_idx[3:0]];
        end
    end

    // Engine model: READ max(|A|,|B|) cycles, one COMPUTE, WRITE |C| cycles, ERROR one cycle.
    matmul_state_t eng_st = IDLE;
    int e_ra = 0, e_ka = 0, e_cb = 0, e_n = 0, e_cnt = 0, e_w = 0;
    logic [31:0] e_a[16], e_b[16], e_c[16];

    function automatic logic [31:0] eng_elem(input int i);
        logic [31:0] s;
        s = 0;
        if (e_cb == 0) return 0;
        for (int k = 0; k < e_ka; k++)
            s += e_a[(i / e_cb) * e_ka + k] * e_b[k * e_cb + (i % e_cb)];
        return s;
    endfunction

    always @(posedge clk) begin
        case (eng_st)
            IDLE: if (mm_start) begin
                e_ra <= int'(mm_dims_a[63:32]);
                e_ka <= int'(mm_dims_a[31:0]);
                e_cb <= int'(mm_dims_b[31:0]);
                e_n  <= (mm_dims_a[63:32] * mm_dims_a[31:0] > mm_dims_b[63:32] * mm_dims_b[31:0]) ?
                        int'(mm_dims_a[63:32] * mm_dims_a[31:0]) : int'(mm_dims_b[63:32] * mm_dims_b[31:0]);
                e_cnt <= 0;
                eng_st <= (mm_dims_a[31:0] != mm_dims_b[63:32]) ? ERROR : READ;
            end
            READ: begin
                if (e_cnt < 16) begin
                    e_a[e_cnt] <= mm_in_a;
                    e_b[e_cnt] <= mm_in_b;
                end
                e_cnt <= e_cnt + 1;
                if (e_cnt + 1 >= e_n) eng_st <= COMPUTE;
            end
            COMPUTE: begin
                for (int i = 0; i < 16; i++) e_c[i] <= eng_elem(i);
                e_w <= 0;
                eng_st <= WRITE;
            end
            WRITE: begin
                e_w <= e_w + 1;
                if (e_w + 1 >= e_ra * e_cb) eng_st <= IDLE;
            end
            default: eng_st <= IDLE;
        endcase
    end

    assign mm_state = eng_st;
    assign mm_out_c = (eng_st == WRITE && e_w < 16) ? e_c[e_w] : 32'h0;

    // Reference model state
    int checks = 0, errors = 0;
    int m_last = 3;
    int exp_ok[4], exp_err[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int rr_next(input int last, input logic [3:0] m);
        for (int i = 1; i <= 4; i++) if (m[(last + i) % 4]) return (last + i) % 4;
        return 0;
    endfunction

    function automatic logic [31:0] ref_c(input int q, input int idx);
        int r, c;
        logic [31:0] s;
        r = idx / int'(cb[q]);
        c = idx % int'(cb[q]);
        s = 0;
        for (int k = 0; k < int'(ka[q]); k++)
            s += ma[q][r * int'(ka[q]) + k] * mb[q][k * int'(cb[q]) + c];
        return s;
    endfunction

    task automatic set_req(input int q, input int a_r, input int a_k, input int b_k, input int b_c);
        ra[q] = a_r; ka[q] = a_k; kb[q] = b_k; cb[q] = b_c;
        for (int i = 0; i < 16; i++) begin
            ma[q][i] = 32'($urandom_range(0, 255));
            mb[q][i] = 32'($urandom_range(0, 255));
        end
    endtask

    task automatic rand_req(input int q, input bit bad);
        int k;
        k = $urandom_range(1, 3);
        set_req(q, $urandom_range(1, 3), k, bad ? (k % 3) + 1 : k, $urandom_range(1, 3));
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            exp_ok[i] = 0;
            exp_err[i] = 0;
        end
    endtask

    // Runs one job from the current negedge to the negedge where done/err pulses.
    task automatic run_job(input logic [3:0] mask, input bit drop,
                           output logic [3:0] got_gnt, output bit got_err);
        int q, t, rd, n_out, starts;
        bit fin, bad;
        req = mask;
        q = rr_next(m_last, mask);
        bad = (ka[q] != kb[q]);
        t = 0;
        while (gnt == 4'b0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        got_gnt = gnt;
        chk("grant", gnt, 64'(4'b1 << q));
        chk("start_with_grant", mm_start, 1);
        chk("mm_dims_a", mm_dims_a, {32'(ra[q]), 32'(ka[q])});
        chk("mm_dims_b", mm_dims_b, {32'(kb[q]), 32'(cb[q])});
        m_last = q;
        starts = 1; rd = 0; n_out = 0; fin = 0; t = 0;
        while (!fin && t < 200) begin
            @(negedge clk);
            t++;
            if (mm_start) starts++;
            if (mm_state == READ) begin
                chk("elem_idx", elem_idx, rd);
                rd++;
            end
            if (out_valid) begin
                chk("out_idx", out_idx, n_out);
                chk("out_c", out_c, ref_c(q, n_out));
                n_out++;
            end
            if (done != 0 || err != 0) fin = 1;
            else chk("gnt_hold", gnt, 64'(4'b1 << q));
        end
        if (!fin) chk("job_timeout", 0, 1);
        got_err = (err != 0);
        chk("done", done, bad ? 0 : 64'(4'b1 << q));
        chk("err", err, bad ? 64'(4'b1 << q) : 0);
        chk("n_out", n_out, bad ? 0 : ra[q] * cb[q]);
        chk("start_count", starts, 1);
        chk("gnt_cleared", gnt, 0);
        chk("busy_after", busy, bad ? 1 : 0);
        if (bad) exp_err[q]++;
        else exp_ok[q]++;
        if (drop) req[q] = 1'b0;
    endtask

    task automatic do_reset();
        int t;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_elem_idx", elem_idx, 0);
        chk("rst_out_idx", out_idx, 0);
        rst = 1'b0;
        m_last = 3;
        clear_stats();
        t = 0;
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("idle_after_rst", busy, 0);
        chk("idle_gnt", gnt, 0);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         q, a_r, a_k, b_k, b_c;
        logic [3:0] exp_gnt;
        bit         exp_err;
    } vec_t;

    initial begin
        vec_t        tbl[8];
        logic [3:0]  g, m;
        bit          e;
        int          t;
        logic [3:0]  order[5];

        tbl[0] = '{4'b0010, 1, 2, 2, 2, 2, 4'b0010, 0};
        tbl[1] = '{4'b0001, 0, 2, 3, 4, 2, 4'b0001, 1};
        tbl[2] = '{4'b0100, 2, 3, 2, 2, 3, 4'b0100, 0};
        tbl[3] = '{4'b1000, 3, 1, 3, 3, 1, 4'b1000, 0};
        tbl[4] = '{4'b1001, 0, 3, 3, 3, 3, 4'b0001, 0};
        tbl[5] = '{4'b1000, 3, 2, 1, 1, 2, 4'b1000, 0};
        tbl[6] = '{4'b0110, 1, 1, 1, 1, 1, 4'b0010, 0};
        tbl[7] = '{4'b0100, 2, 3, 1, 2, 2, 4'b0100, 1};
        order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1;
        req = '0;
        for (int q = 0; q < 4; q++) set_req(q, 1, 1, 1, 1);
        clear_stats();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].q, tbl[i].a_r, tbl[i].a_k, tbl[i].b_k, tbl[i].b_c);
            run_job(tbl[i].mask, 1, g, e);
            chk("tbl_gnt", g, tbl[i].exp_gnt);
            chk("tbl_err", e, tbl[i].exp_err);
        end

        // All four requesting continuously from reset: rotation starts at 0.
        do_reset();
        for (int q = 0; q < 4; q++) rand_req(q, 0);
        for (int i = 0; i < 5; i++) begin
            run_job(4'b1111, 0, g, e);
            chk("rr_order", g, order[i]);
        end

        // Reset in the middle of a READ phase: ownership dropped, no grant until engine drains.
        req = '0;
        do_reset();
        set_req(0, 3, 3, 3, 3);
        req = 4'b0001;
        t = 0;
        while (mm_state != READ && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("reached_read", mm_state, READ);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midjob_rst_gnt", gnt, 0);
        chk("midjob_rst_busy", busy, 1);
        rst = 1'b0;
        m_last = 3;
        clear_stats();
        t = 0;
        while (mm_state != IDLE && t < 100) begin
            chk("drain_gnt", gnt, 0);
            chk("drain_out_valid", out_valid, 0);
            chk("drain_mm_in_a", mm_in_a, 0);
            @(negedge clk);
            t++;
        end
        chk("drain_done", mm_state, IDLE);
        run_job(4'b0001, 1, g, e);
        chk("regrant_after_drain", g, 4'b0001);

        // Randomized traffic against the round-robin and matmul reference.
        for (int j = 0; j < 30; j++) begin
            for (int q = 0; q < 4; q++) if (!req[q]) rand_req(q, $urandom_range(0, 3) == 0);
            m = req | 4'($urandom_range(0, 15));
            if (m == 4'b0) m = 4'b0100;
            run_job(m, 1, g, e);
        end

`ifdef MATMUL_SCHED_STATS_EN
        repeat (2) @(negedge clk);
        for (int q = 0; q < 4; q++) begin
            chk("jobs_ok", jobs_ok[q*16 +: 16], exp_ok[q]);
            chk("jobs_err", jobs_err[q*16 +: 16], exp_err[q]);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
